program_loader: RTL

- Serial boot loader and instruction store in front of the CPU; replaces the fixed instruction ROM.
- Receives a framed program image over a UART line and writes it into an internal instruction RAM.
- Holds the CPU in reset while loading, then serves instruction = mem[pc] combinationally, with the same timing the ROM had.
- Allows a new image to be downloaded at any time without reconfiguring the FPGA.

---
 rtl/program_loader_pkg.sv | 25 ++
 rtl/program_loader_uart_rx.sv | 97 +++++++++
 rtl/program_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: frame FSM states,
// UART receiver states and the frame sync byte.
package program_loader_pkg;

  typedef enum logic [2:0] {
    SYNC,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    RUN,
    ERR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver, LSB first. Start bit confirmed at half a bit period,
// data and stop bits sampled at mid-bit. Emits one-cycle byte_valid or
// framing_err pulses. Reusable by other serial peripherals.
module uart_rx
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state, next_state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (reset) state <= RX_IDLE;
    else       state <= next_state;
  end

  // Next state: a start that is high again at half-bit is a glitch
  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) next_state = RX_START;
      RX_START: if (cnt == HALF_M1) next_state = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == FULL_M1 && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (cnt == FULL_M1) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  // Bit timing counter, shift register and result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      data        <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: cnt <= (cnt == HALF_M1) ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            data    <= {rx_sync, data[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt         <= '0;
            byte_valid  <= rx_sync;
            framing_err <= !rx_sync;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial boot loader and instruction RAM. Receives a framed image over UART,
// holds the CPU in reset while loading and serves mem[pc] combinationally.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 12,
  parameter int DEPTH        = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] pc,
  output logic [15:0] instruction,
  output logic        cpu_reset,
  output logic        loading,
  output logic        error
);

  load_state_t       state, next_state;
  logic [7:0]        data;
  logic              byte_valid, framing_err;
  logic [7:0]        len_hi, len_lo, hi, csum;
  logic [ADDR_W-1:0] word_idx;
  logic [15:0]       mem [DEPTH];
  logic [15:0]       len_now;
  logic              last_word;
  logic              cpu_reset_d, loading_d, error_d;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .byte_valid  (byte_valid),
    .framing_err (framing_err)
  );

  assign len_now   = {len_hi, data};
  assign last_word = ({{(16 - ADDR_W){1'b0}}, word_idx} == ({len_hi, len_lo} - 16'd1));

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= next_state;
  end

  // Frame parsing: framing errors abort a load, bytes advance the frame
  always_comb begin
    next_state = state;
    if (framing_err && state != SYNC && state != RUN) begin
      next_state = ERR;
    end else if (byte_valid) begin
      case (state)
        SYNC:    if (data == SYNC_BYTE) next_state = LEN_HI;
        LEN_HI:  next_state = LEN_LO;
        LEN_LO: begin
          if ({1'b0, len_now} > 17'(DEPTH)) next_state = ERR;
          else if (len_now == 16'd0)        next_state = CSUM;
          else                              next_state = DATA_HI;
        end
        DATA_HI: next_state = DATA_LO;
        DATA_LO: next_state = last_word ? CSUM : DATA_HI;
        CSUM:    next_state = (data == csum) ? RUN : ERR;
        RUN:     if (data == SYNC_BYTE) next_state = LEN_HI;
        default: next_state = ERR;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs track it
  always_comb begin
    cpu_reset_d = (next_state != RUN);
    loading_d   = (next_state == LEN_HI) || (next_state == LEN_LO) ||
                  (next_state == DATA_HI) || (next_state == DATA_LO) ||
                  (next_state == CSUM);
    error_d     = (next_state == ERR);
  end

  // Registered CPU control and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset <= 1'b1;
      loading   <= 1'b0;
      error     <= 1'b0;
    end else begin
      cpu_reset <= cpu_reset_d;
      loading   <= loading_d;
      error     <= error_d;
    end
  end

  // Length, high byte, word index and running checksum
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx <= '0;
      csum     <= '0;
      len_hi   <= '0;
      len_lo   <= '0;
      hi       <= '0;
    end else if (byte_valid) begin
      case (state)
        SYNC, RUN: if (data == SYNC_BYTE) csum <= '0;
        LEN_HI: begin
          len_hi <= data;
          csum   <= csum ^ data;
        end
        LEN_LO: begin
          len_lo   <= data;
          csum     <= csum ^ data;
          word_idx <= '0;
        end
        DATA_HI: begin
          hi   <= data;
          csum <= csum ^ data;
        end
        DATA_LO: begin
          csum <= csum ^ data;
          if (!last_word) word_idx <= word_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM write port; contents are not touched by reset
  always_ff @(posedge clk) begin
    if (!reset && byte_valid && state == DATA_LO) mem[word_idx] <= {hi, data};
  end

  // Combinational fetch; addresses beyond the RAM read as zero
  always_comb begin
    instruction = 16'h0000;
    if (pc[15:ADDR_W] == '0) instruction = mem[pc[ADDR_W-1:0]];
  end

endmodule
